// File: rtl/seq_detector_1101_pkg.sv
// Shared definitions for the 1101 sequence detector: state codes, state width
// and the default detection-counter width.
package seq_detector_1101_pkg;

  localparam int STATE_W       = 3;
  localparam int CNT_WIDTH_DEF = 4;

  typedef enum logic [STATE_W-1:0] {
    S0    = 3'd0,
    S1    = 3'd1,
    S11   = 3'd2,
    S110  = 3'd3,
    S1101 = 3'd4
  } state_e;

endpackage

// File: rtl/seq_detector_1101_state_reg_sr.sv
// State register for the detector: a bank of plain D flip-flops with the
// synchronous reset folded into each D input.
module d_flip_flop (
  input  logic clk_i,
  input  logic d_i,
  output logic q_o
);

  always_ff @(posedge clk_i) begin
    q_o <= d_i;
  end

endmodule

module state_reg_sr #(
  parameter int W = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] d_gated;

  // Reset wins over the next-state value, so the flops themselves stay reset-free.
  assign d_gated = rst_i ? '0 : d_i;

  for (genvar i = 0; i < W; i++) begin : g_bit
    d_flip_flop u_ff (
      .clk_i (clk_i),
      .d_i   (d_gated[i]),
      .q_o   (q_o[i])
    );
  end

endmodule

// File: rtl/seq_detector_1101.sv
// Moore detector for the overlapping serial pattern 1101, with a saturating
// detection counter and a sticky overflow flag.
module seq_detector_1101
  import seq_detector_1101_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 En,
  input  logic                 Din,
  output logic                 Detect,
  output logic [CNT_WIDTH-1:0] Count,
  output logic                 Overflow
);

  logic [STATE_W-1:0]   state_q;
  logic [STATE_W-1:0]   state_d;
  logic                 hit;
  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;
  logic                 overflow_q;
  logic                 overflow_d;

  state_reg_sr #(.W(STATE_W)) u_state_reg (
    .clk_i (Clk),
    .rst_i (Reset),
    .d_i   (state_d),
    .q_o   (state_q)
  );

  always_comb begin
    state_d = state_q;
    hit     = 1'b0;
    case (state_q)
      S0:    if (En) state_d = Din ? S1    : S0;
      S1:    if (En) state_d = Din ? S11   : S0;
      S11:   if (En) state_d = Din ? S11   : S110;
      S110:  if (En) begin
               state_d = Din ? S1101 : S0;
               hit     = Din;
             end
      S1101: if (En) state_d = Din ? S11   : S0;
      // Illegal codes recover to S0 even while sampling is disabled.
      default: state_d = S0;
    endcase
  end

  always_comb begin
    count_d    = count_q;
    overflow_d = overflow_q;
    if (hit) begin
      if (&count_q) overflow_d = 1'b1;
      else          count_d    = count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign Detect   = (state_q == S1101);
  assign Count    = count_q;
  assign Overflow = overflow_q;

endmodule

// File: tb/tb_seq_detector_1101.sv
// Scoreboard bench for seq_detector_1101 (CNT_WIDTH=2): directed vectors push
// hand-computed expectations; a monitor pops and checks after each clock edge.
module tb_seq_detector_1101;

  typedef struct {
    int         tag;
    logic       det;
    logic [1:0] cnt;
    logic       ovf;
    bit         chk_st;
    logic [2:0] st;
  } exp_t;

  logic       Clk;
  logic       Reset;
  logic       En;
  logic       Din;
  logic       Detect;
  logic [1:0] Count;
  logic       Overflow;

  exp_t exp_q[$];
  exp_t e;
  int   n_checks;
  int   n_fail;
  int   tag;

  seq_detector_1101 #(.CNT_WIDTH(2)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .En       (En),
    .Din      (Din),
    .Detect   (Detect),
    .Count    (Count),
    .Overflow (Overflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input int t, input logic [2:0] act, input logic [2:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, t, act, exp);
    end
  endtask

  // Drive one edge worth of inputs and queue what must be visible after it.
  task automatic step(input logic rst, input logic en, input logic din,
                      input logic edet, input logic [1:0] ecnt, input logic eovf,
                      input bit chk_st = 1'b0, input logic [2:0] est = 3'd0);
    exp_t x;
    @(negedge Clk);
    Reset = rst;
    En    = en;
    Din   = din;
    tag++;
    x.tag = tag; x.det = edet; x.cnt = ecnt; x.ovf = eovf;
    x.chk_st = chk_st; x.st = est;
    exp_q.push_back(x);
  endtask

  initial begin
    forever begin
      @(posedge Clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("detect",   e.tag, {2'b00, Detect},   {2'b00, e.det});
        check("count",    e.tag, {1'b0, Count},     {1'b0, e.cnt});
        check("overflow", e.tag, {2'b00, Overflow}, {2'b00, e.ovf});
        if (e.chk_st) check("state", e.tag, dut.state_q, e.st);
      end
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    tag      = 0;
    Reset    = 1'b1;
    En       = 1'b0;
    Din      = 1'b0;

    // 1: basic detect, then S0 after a trailing 0
    step(1, 1, 0, 0, 0, 0, 1, 3'd0);
    step(1, 1, 0, 0, 0, 0, 1, 3'd0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 1, 3'd3);
    step(0, 1, 1, 1, 1, 0, 1, 3'd4);
    step(0, 1, 0, 0, 1, 0, 1, 3'd0);

    // 2: overlapping patterns 1101101
    step(1, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 1, 1, 0);
    step(0, 1, 1, 0, 1, 0, 1, 3'd2);
    step(0, 1, 0, 0, 1, 0);
    step(0, 1, 1, 1, 2, 0);
    step(0, 1, 0, 0, 2, 0, 1, 3'd0);

    // 3: enable gating, including a park in S1101
    step(1, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 3'd2);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 3'd2);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 1, 1, 0);
    step(0, 0, 1, 1, 1, 0);
    step(0, 0, 1, 1, 1, 0);
    step(0, 0, 0, 1, 1, 0, 1, 3'd4);
    step(0, 1, 0, 0, 1, 0);

    // 4: saturation at 3, overflow on the fourth hit, cleared by reset
    step(1, 1, 0, 0, 0, 0);
    for (int p = 1; p <= 4; p++) begin
      step(0, 1, 1, 0, (p > 3) ? 2'd3 : 2'(p - 1), 0);
      step(0, 1, 1, 0, (p > 3) ? 2'd3 : 2'(p - 1), 0);
      step(0, 1, 0, 0, (p > 3) ? 2'd3 : 2'(p - 1), 0);
      step(0, 1, 1, 1, (p > 3) ? 2'd3 : 2'(p),     (p == 4));
      step(0, 1, 0, 0, (p > 3) ? 2'd3 : 2'(p),     (p == 4));
    end
    step(0, 0, 1, 0, 3, 1);
    step(1, 1, 1, 0, 0, 0, 1, 3'd0);

    // 5: reset mid-pattern discards the partial match
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 1, 3'd3);
    step(1, 1, 1, 0, 0, 0, 1, 3'd0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 1, 3'd1);

    // 6: illegal state code recovers to S0 with En low
    step(1, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    @(negedge Clk);
    force dut.state_d = 3'd6;
    step(0, 0, 0, 0, 0, 0, 1, 3'd6);
    @(posedge Clk);
    #2;
    release dut.state_d;
    step(0, 0, 1, 0, 0, 0, 1, 3'd0);
    step(0, 1, 1, 0, 0, 0, 1, 3'd1);

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge Clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
